// File: rtl/quantizer_stream.sv
// Streaming quantizer: per-coefficient arithmetic shift from a two-bank table, round-half-up, signed saturation.
// Latency: 2 cycles from input accept to output valid; throughput one coefficient per cycle.
// Backpressure: one global enable advances S1 and S2 together; out_* hold while out_valid && !out_ready.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cfg_we/cfg_bank/cfg_addr/cfg_data shift-table write (only while cfg_ready; blocks input that cycle)
//   cfg_ready                        high when no partial block is in the counter or the pipe
//   in_valid/in_ready/in_data/in_bank coefficient stream in raster order; in_bank sampled on beat 0
//   out_valid/out_ready/out_data     quantized coefficient stream
//   out_last/out_sat                 last beat of block / coefficient was clamped
//   blk_sat_count/blk_done           saturations in last finished block / pulse when it completes
module quantizer_stream #(
  parameter int BLOCK_SIZE    = 8,
  parameter int DCT_OUT_WIDTH = 54,
  parameter int COEFF_WIDTH   = 9,
  parameter int SHIFT_WIDTH   = 4,
  parameter int FRAC_BITS     = 32,
  localparam int N     = BLOCK_SIZE * BLOCK_SIZE,
  localparam int IDX_W = $clog2(N),
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic                     cfg_bank,
  input  logic [IDX_W-1:0]         cfg_addr,
  input  logic [SHIFT_WIDTH-1:0]   cfg_data,
  output logic                     cfg_ready,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DCT_OUT_WIDTH-1:0] in_data,
  input  logic                     in_bank,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COEFF_WIDTH-1:0]   out_data,
  output logic                     out_last,
  output logic                     out_sat,
  output logic [CNT_W-1:0]         blk_sat_count,
  output logic                     blk_done
);

  localparam int IW   = DCT_OUT_WIDTH + 1;
  // Largest first-stage shift is FRAC_BITS + 2^SHIFT_WIDTH - 2, always below DCT_OUT_WIDTH.
  localparam int SH_W = $clog2(DCT_OUT_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic signed [IW-1:0] SAT_MAX =
    $signed({{(IW-COEFF_WIDTH+1){1'b0}}, {(COEFF_WIDTH-1){1'b1}}});
  localparam logic signed [IW-1:0] SAT_MIN =
    $signed({{(IW-COEFF_WIDTH+1){1'b1}}, {(COEFF_WIDTH-1){1'b0}}});

  // State
  logic [SHIFT_WIDTH-1:0]           tbl_q [2][N];
  logic [SHIFT_WIDTH-1:0]           tbl_d [2][N];
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic                             bank_q, bank_d;
  logic                             s1_vld_q, s1_vld_d;
  logic signed [DCT_OUT_WIDTH-1:0]  s1_y_q, s1_y_d;
  logic                             s1_last_q, s1_last_d;
  logic                             s2_vld_q, s2_vld_d;
  logic [COEFF_WIDTH-1:0]           out_data_q, out_data_d;
  logic                             out_sat_q, out_sat_d;
  logic                             out_last_q, out_last_d;
  logic [CNT_W-1:0]                 run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]                 blk_sat_count_q, blk_sat_count_d;
  logic                             blk_done_q, blk_done_d;

  // Combinational helpers
  logic                             en;
  logic                             cfg_wr;
  logic                             in_acc;
  logic                             out_acc;
  logic                             cur_bank;
  logic [SHIFT_WIDTH-1:0]           tbl_sh;
  logic [SH_W-1:0]                  sh_m1;
  logic signed [DCT_OUT_WIDTH-1:0]  y;
  logic signed [IW-1:0]             y_ext;
  logic signed [IW-1:0]             y_half;
  logic signed [IW-1:0]             rnd_bit;
  logic signed [IW-1:0]             r;
  logic                             sat_hi;
  logic                             sat_lo;

  assign en        = !s2_vld_q || out_ready;
  assign cfg_ready = (idx_q == '0) && !s1_vld_q && !s2_vld_q;
  assign cfg_wr    = cfg_we && cfg_ready;
  assign in_ready  = en && !cfg_wr;
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = s2_vld_q && out_ready;

  assign out_valid     = s2_vld_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign out_sat       = out_sat_q;
  assign blk_sat_count = blk_sat_count_q;
  assign blk_done      = blk_done_q;

  // S1 arithmetic: shift by one less than the total so the dropped half-LSB survives in y[0].
  always_comb begin
    cur_bank = (idx_q == '0) ? in_bank : bank_q;
    tbl_sh   = tbl_q[cur_bank][idx_q];
    sh_m1    = SH_W'(FRAC_BITS - 1) + SH_W'(tbl_sh);
    y        = $signed(in_data) >>> sh_m1;
  end

  // S2 arithmetic: final halving plus the saved half-LSB gives round-half-up (toward +inf).
  always_comb begin
    y_ext   = {s1_y_q[DCT_OUT_WIDTH-1], s1_y_q};
    y_half  = y_ext >>> 1;
    rnd_bit = $signed({{(IW-1){1'b0}}, s1_y_q[0]});
    r       = y_half + rnd_bit;
    sat_hi  = r > SAT_MAX;
    sat_lo  = r < SAT_MIN;
  end

  always_comb begin
    tbl_d           = tbl_q;
    idx_d           = idx_q;
    bank_d          = bank_q;
    s1_vld_d        = s1_vld_q;
    s1_y_d          = s1_y_q;
    s1_last_d       = s1_last_q;
    s2_vld_d        = s2_vld_q;
    out_data_d      = out_data_q;
    out_sat_d       = out_sat_q;
    out_last_d      = out_last_q;
    run_cnt_d       = run_cnt_q;
    blk_sat_count_d = blk_sat_count_q;
    blk_done_d      = 1'b0;

    if (cfg_wr) begin
      tbl_d[cfg_bank][cfg_addr] = cfg_data;
    end

    if (in_acc) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      if (idx_q == '0) begin
        bank_d = in_bank;
      end
    end

    // Both stages move only together; payload registers load only with valid data.
    if (en) begin
      s1_vld_d = in_acc;
      if (in_acc) begin
        s1_y_d    = y;
        s1_last_d = (idx_q == LAST_IDX);
      end
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        out_last_d = s1_last_q;
        out_sat_d  = sat_hi || sat_lo;
        if (sat_hi) begin
          out_data_d = {1'b0, {(COEFF_WIDTH-1){1'b1}}};
        end else if (sat_lo) begin
          out_data_d = {1'b1, {(COEFF_WIDTH-1){1'b0}}};
        end else begin
          out_data_d = r[COEFF_WIDTH-1:0];
        end
      end
    end

    if (out_acc) begin
      if (out_last_q) begin
        blk_sat_count_d = run_cnt_q + CNT_W'(out_sat_q);
        run_cnt_d       = '0;
        blk_done_d      = 1'b1;
      end else begin
        run_cnt_d = run_cnt_q + CNT_W'(out_sat_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          tbl_q[b][i] <= '0;
        end
      end
      idx_q           <= '0;
      bank_q          <= 1'b0;
      s1_vld_q        <= 1'b0;
      s1_y_q          <= '0;
      s1_last_q       <= 1'b0;
      s2_vld_q        <= 1'b0;
      out_data_q      <= '0;
      out_sat_q       <= 1'b0;
      out_last_q      <= 1'b0;
      run_cnt_q       <= '0;
      blk_sat_count_q <= '0;
      blk_done_q      <= 1'b0;
    end else begin
      tbl_q           <= tbl_d;
      idx_q           <= idx_d;
      bank_q          <= bank_d;
      s1_vld_q        <= s1_vld_d;
      s1_y_q          <= s1_y_d;
      s1_last_q       <= s1_last_d;
      s2_vld_q        <= s2_vld_d;
      out_data_q      <= out_data_d;
      out_sat_q       <= out_sat_d;
      out_last_q      <= out_last_d;
      run_cnt_q       <= run_cnt_d;
      blk_sat_count_q <= blk_sat_count_d;
      blk_done_q      <= blk_done_d;
    end
  end

endmodule

// File: tb/tb_quantizer_stream.sv
// Bench for quantizer_stream: randomized and directed blocks checked by a queue scoreboard.
// Expected values come from a divide-and-round reference model of the quantizer rules.
// A free-running monitor pops and compares on every accepted output beat.
module tb_quantizer_stream;
  localparam int N    = 64;
  localparam int FRAC = 32;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic        cfg_bank;
  logic [5:0]  cfg_addr;
  logic [3:0]  cfg_data;
  logic        cfg_ready;
  logic        in_valid;
  logic        in_ready;
  logic [53:0] in_data;
  logic        in_bank;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_data;
  logic        out_last;
  logic        out_sat;
  logic [6:0]  blk_sat_count;
  logic        blk_done;

  quantizer_stream dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_bank(cfg_bank), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_bank(in_bank),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_sat(out_sat),
    .blk_sat_count(blk_sat_count), .blk_done(blk_done)
  );

  typedef struct {
    logic signed [8:0] data;
    bit                sat;
    bit                last;
    bit                chk_lat;
    int                acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          mtbl[2][N];
  int          m_idx;
  bit          m_bank;
  int          ready_mode;
  int          cyc;
  int          checks;
  int          errors;
  logic [53:0] bd[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Downstream ready pattern: 0 always ready, 1 toggling, 2 random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = !out_ready;
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: q = floor(x / 2^sh + 1/2), then clamp to the signed 9-bit range.
  function automatic void ref_model(input logic signed [53:0] x, input int sh,
                                    output logic signed [8:0] q, output bit sat);
    longint v;
    v   = (longint'(x) + (longint'(1) <<< (sh - 1))) >>> sh;
    sat = 1'b0;
    if (v > 255) begin
      q   = 9'(255);
      sat = 1'b1;
    end else if (v < -256) begin
      q   = 9'(-256);
      sat = 1'b1;
    end else begin
      q = 9'(v);
    end
  endfunction

  function automatic logic [53:0] rnd_coef();
    logic [63:0]        r;
    logic signed [53:0] v;
    r = {$urandom, $urandom};
    v = r[53:0];
    return v >>> $urandom_range(0, 20);
  endfunction

  // Present one beat (back-to-back with the previous), wait for accept, push expectation.
  task automatic send_beat(input logic [53:0] d, input bit b);
    int   g;
    bit   acc;
    int   sh;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_bank  = (m_idx == 0) ? b : 1'($urandom);
    g   = 0;
    acc = 1'b0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
      g++;
      if (g > 1000) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout beat %0d never accepted", m_idx);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc) begin
      if (m_idx == 0) m_bank = b;
      sh = FRAC + mtbl[m_bank][m_idx];
      ref_model(d, sh, e.data, e.sat);
      e.last    = (m_idx == N - 1);
      e.chk_lat = (ready_mode == 0);
      e.acc_cyc = cyc;
      exp_q.push_back(e);
      m_idx = (m_idx + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_range(input int start, input int cnt, input bit b);
    for (int i = start; i < start + cnt; i++) send_beat(bd[i], b);
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input int bank, input int addr, input int data, input bit exp_acc);
    cfg_we   = 1'b1;
    cfg_bank = 1'(bank);
    cfg_addr = 6'(addr);
    cfg_data = 4'(data);
    @(negedge clk);
    chk("cfg_ready", cfg_ready, exp_acc);
    if (exp_acc) chk("in_ready_during_cfg", in_ready, 0);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (exp_acc) mtbl[bank][addr] = data;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int m);
    ready_mode = m;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_bd();
    for (int i = 0; i < N; i++) bd[i] = '0;
  endtask

  // Monitor / scoreboard
  initial begin
    logic [8:0] h_data;
    bit         h_last, h_sat, stall, pend;
    int         run, blk_cur;
    exp_t       e;
    stall = 0; pend = 0; run = 0; blk_cur = 0;
    h_data = '0; h_last = 0; h_sat = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 0; pend = 0; run = 0; blk_cur = 0;
        continue;
      end
      chk("blk_done", blk_done, pend);
      chk("blk_sat_count", blk_sat_count, blk_cur);
      pend = 0;
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", $signed(out_data), $signed(h_data));
        chk("stall_last", out_last, h_last);
        chk("stall_sat", out_sat, h_sat);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output data %0d with empty scoreboard", $signed(out_data));
        end else begin
          e = exp_q.pop_front();
          chk("out_data", $signed(out_data), e.data);
          chk("out_sat", out_sat, e.sat);
          chk("out_last", out_last, e.last);
          if (e.chk_lat) chk("latency", cyc - e.acc_cyc, 2);
          run += int'(e.sat);
          if (e.last) begin
            blk_cur = run;
            run     = 0;
            pend    = 1;
          end
        end
      end
      stall  = out_valid && !out_ready;
      h_data = out_data;
      h_last = out_last;
      h_sat  = out_sat;
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_bank = 1'b0;
    cfg_we = 1'b0; cfg_bank = 1'b0; cfg_addr = '0; cfg_data = '0;
    ready_mode = 0; m_idx = 0; m_bank = 1'b0;
    for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) mtbl[b][i] = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_blk_sat_count", blk_sat_count, 0);
    chk("rst_blk_done", blk_done, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // +-1.5 rounds to 2 and -1; everything else 0.
    clear_bd();
    bd[0] = 54'(longint'(3) <<< 31);
    bd[1] = 54'(-(longint'(3) <<< 31));
    send_range(0, N, 1'b0);
    drain();

    // Bank 1 entry 0 shift 3: 20/8 = 2.5 -> 3; same data on bank 0 -> 20.
    cfg_write(1, 0, 3, 1'b1);
    clear_bd();
    bd[0] = 54'(longint'(20) <<< 32);
    send_range(0, N, 1'b1);
    send_range(0, N, 1'b0);
    drain();

    // Saturation both ways plus the largest in-range value.
    clear_bd();
    bd[0] = 54'(longint'(300) <<< 32);
    bd[1] = 54'(-(longint'(300) <<< 32));
    bd[2] = 54'(longint'(255) <<< 32);
    send_range(0, N, 1'b0);
    drain();

    // Toggling backpressure across a random block.
    set_mode(1);
    for (int i = 0; i < N; i++) bd[i] = rnd_coef();
    send_range(0, N, 1'b0);
    drain();
    set_mode(0);

    // Write attempt mid-block is ignored; idle write takes effect.
    clear_bd();
    bd[5] = 54'(longint'(100) <<< 32);
    send_range(0, 10, 1'b0);
    cfg_write(0, 5, 7, 1'b0);
    send_range(10, N - 10, 1'b0);
    send_range(0, N, 1'b0);
    drain();
    cfg_write(0, 5, 7, 1'b1);
    send_range(0, N, 1'b0);
    drain();

    // Random tables and blocks under random backpressure.
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) cfg_write(b, i, int'($urandom_range(0, 15)), 1'b1);
    set_mode(2);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) bd[i] = rnd_coef();
      send_range(0, N, 1'(k % 2));
    end
    drain();
    set_mode(0);

    // Reset at index 30 with data in flight.
    for (int i = 0; i < 4; i++) cfg_write(0, i, 5, 1'b1);
    for (int i = 0; i < N; i++) bd[i] = 54'(longint'(i + 1) <<< 32);
    send_range(0, 30, 1'b0);
    chk("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 1);
    exp_q.delete();
    m_idx = 0;
    m_bank = 1'b0;
    for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) mtbl[b][i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_range(0, N, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
